acc_core: RTL and testbench
===========================

Name: acc_core

Overview:
Parametrised multi-cycle accumulator CPU core and successor to the fixed 8-bit single-cycle accumulator CPU. It generalises data, address and instruction widths. Instruction memory, data memory and the I/O ports are external and handshaked, so the core stalls on slow memory and on I/O. It adds an explicit FSM, a HALT instruction and wait-state support, and sits between ROM/RAM wrappers and the board-level I/O.

Parameters:
DW, 8, data/accumulator width
AW, 12, address width for PC and data memory
IW, 16, instruction width; opcode is [IW-1:IW-4]; IW >= 4+max(AW,DW) (elaboration error otherwise)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
imem_req_o  out  1  fetch request
imem_addr_o  out  AW  fetch address (= PC)
imem_rdata_i  in  IW  instruction
imem_valid_i  in  1  instruction valid
dmem_req_o  out  1  data access request
dmem_we_o  out  1  1=write, 0=read
dmem_addr_o  out  AW  = IR[AW-1:0]
dmem_wdata_o  out  DW  = ACC
dmem_rdata_i  in  DW  read data
dmem_ack_i  in  1  access complete
in_data_i  in  DW  input port data
in_valid_i  in  1  input valid
in_ready_o  out  1  core accepting input
out_data_o  out  DW  output data
out_valid_o  out  1  output valid
out_ready_i  in  1  sink ready
pc_o  out  AW  debug PC
ins_o  out  IW  debug IR
acc_o  out  DW  debug ACC
flags_o  out  2  {C,Z}
halted_o  out  1  core in HALT

Behaviour:
- Reset: synchronous, active-low; one clock and rst_i asserted low.
  - On reset: PC=0, IR=0, ACC=0, flags=00, state=FETCH.
  - All req/valid/ready outputs are 0 in the reset cycle; halted_o=0.
  - Reset mid-transaction abandons it with no write-back.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: ACC op mem[IR[AW-1:0]].
  - 5 ADDI: ACC + IR[DW-1:0]. 6 LDI: ACC = IR[DW-1:0]. 7 LD. 8 ST.
  - 9 JMP. A JZ. B JC. C INP. D OUT. E NOP. F HALT.
- FSM states: FETCH, EXEC, MEM, IN, OUT, HALT.
- FETCH:
  - imem_req_o=1 with imem_addr_o=PC, held until imem_valid_i.
  - On the valid cycle: IR <= imem_rdata_i, then go to EXEC.
- EXEC (one cycle):
  - ADDI, LDI, NOP and all jumps complete here: PC update, then FETCH.
  - Opcodes 0-4, LD and ST go to MEM. INP goes to IN. OUT goes to OUT. HALT goes to HALT.
- MEM:
  - dmem_req_o=1 is held until dmem_ack_i.
  - dmem_we_o=1 only for ST.
  - On ack: ACC/flags are written (loads and ALU ops), PC+1, then FETCH.
- IN:
  - in_ready_o=1.
  - On in_valid_i: ACC <= in_data_i, Z updated, C unchanged, PC+1, then FETCH.
- OUT:
  - out_valid_o=1 and out_data_o=ACC, held stable until out_ready_i.
  - Then PC+1, then FETCH.
- HALT:
  - Absorbing state; halted_o=1 and all requests are 0.
  - Only reset exits HALT.
- Latency: minimum 2 cycles per instruction (FETCH with same-cycle valid, plus EXEC); MEM/IN/OUT instructions take a minimum of 3.
- PC:
  - Non-taken instructions: PC+1 mod 2^AW (0x...FFF wraps to 0).
  - Taken JMP/JZ/JC: PC = IR[AW-1:0].
  - JZ and JC test the flags as they stand before the jump; jumps do not alter flags.
- Flags:
  - Z = (ACC result == 0), updated on every ACC write.
  - C on ADD/ADDI = carry out of DW bits; on SUB = borrow (ACC < operand).
  - AND/OR/XOR clear C. LD, LDI and INP preserve C.
  - ST, OUT, NOP and jumps preserve both flags.
- Widths: all arithmetic is DW bits, truncating. The immediate is zero-extended from IR[DW-1:0].
- Back-to-back handshakes: the state machine returns to FETCH, so consecutive valid pulses are not double-consumed.

Decomposition:
- Package acc_pkg: opcode localparams (OP_ADD…OP_HALT), FSM state encoding, flag bit indices.
- Sub-module acc_alu:
  - Combinational; inputs DW-bit a, b and the 3-bit function; outputs result, Z and C.
  - Used for opcodes 0-5; LDI/LD/INP bypass it.
- The core holds the FSM, PC, IR, ACC and flags.

Test Plan:
- LDI 0x05; ADDI 0xFB with imem_valid same-cycle -> ACC=0x00, Z=1, C=1; each instruction takes 2 cycles; PC=2.
- ST 0x010 with ack delayed 3 cycles -> dmem_req/we held high 4 cycles with wdata=ACC stable; PC advances only after ack.
- LDI 0x03; SUB from memory holding 0x04 -> ACC=0xFF, C=1, Z=0; JC 0x100 -> PC=0x100. JZ 0x200 with Z=0 -> PC increments.
- INP with in_valid low 5 cycles then 0xA5 -> in_ready high 6 cycles, ACC=0xA5. OUT with out_ready delayed -> out_valid/out_data=0xA5 stable until ready.
- PC=0xFFF executing NOP -> next fetch at 0x000. HALT -> halted_o=1, no imem_req for 10 cycles. rst_i low for 1 cycle -> PC=0, ACC=0, state FETCH.
- Reset asserted during MEM wait -> next cycle dmem_req=0 and state FETCH; memory write is not retried.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator core: opcodes, FSM states,
// flag bit positions and ALU function codes.
package acc_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_INP  = 4'hC;
    localparam logic [3:0] OP_OUT  = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU function codes line up with the low bits of opcodes 0-5
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_ADDI = 3'd5;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_IN,
        S_OUT,
        S_HALT
    } state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op <= OP_XOR) || (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU for the accumulator core: add/sub/logic ops with
// zero and carry/borrow outputs.
module acc_alu
    import acc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [2:0]    fn,
    output logic [DW-1:0] result,
    output logic          zero,
    output logic          carry
);

    logic [DW:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = b;
        carry  = 1'b0;
        case (fn)
            ALU_ADD, ALU_ADDI: begin
                result = sum[DW-1:0];
                carry  = sum[DW];
            end
            ALU_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: ;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/acc_core.sv
// Multi-cycle accumulator CPU core with handshaked instruction memory,
// data memory and I/O ports; stalls in each state until its handshake completes.
module acc_core
    import acc_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 12,
    parameter int IW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          imem_req_o,
    output logic [AW-1:0] imem_addr_o,
    input  logic [IW-1:0] imem_rdata_i,
    input  logic          imem_valid_i,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [AW-1:0] dmem_addr_o,
    output logic [DW-1:0] dmem_wdata_o,
    input  logic [DW-1:0] dmem_rdata_i,
    input  logic          dmem_ack_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic [DW-1:0] out_data_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [AW-1:0] pc_o,
    output logic [IW-1:0] ins_o,
    output logic [DW-1:0] acc_o,
    output logic [1:0]    flags_o,
    output logic          halted_o
);

    localparam int MAXW = (AW > DW) ? AW : DW;

    generate
        if (IW < 4 + MAXW) begin : g_width_check
            $error("acc_core: IW must be at least 4+max(AW,DW)");
        end
    endgenerate

    state_t        state, next_state;
    logic [AW-1:0] pc;
    logic [IW-1:0] ir;
    logic [DW-1:0] acc;
    logic [1:0]    flags;

    logic [3:0]    opcode;
    logic [AW-1:0] target;
    logic [AW-1:0] pc_next;
    logic [DW-1:0] imm;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          alu_carry;

    assign opcode  = ir[IW-1:IW-4];
    assign target  = ir[AW-1:0];
    assign imm     = ir[DW-1:0];
    assign pc_next = pc + AW'(1);
    assign alu_b   = (opcode == OP_ADDI) ? imm : dmem_rdata_i;

    acc_alu #(.DW(DW)) u_alu (
        .a      (acc),
        .b      (alu_b),
        .fn     (opcode[2:0]),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: if (imem_valid_i) next_state = S_EXEC;
            S_EXEC: begin
                if (is_mem_op(opcode))       next_state = S_MEM;
                else if (opcode == OP_INP)   next_state = S_IN;
                else if (opcode == OP_OUT)   next_state = S_OUT;
                else if (opcode == OP_HALT)  next_state = S_HALT;
                else                         next_state = S_FETCH;
            end
            S_MEM:   if (dmem_ack_i)   next_state = S_FETCH;
            S_IN:    if (in_valid_i)   next_state = S_FETCH;
            S_OUT:   if (out_ready_i)  next_state = S_FETCH;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_FETCH;
        endcase
    end

    // Handshake outputs are masked while reset is held so nothing leaks in the reset cycle
    always_comb begin
        imem_req_o  = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        halted_o    = 1'b0;
        if (rst_i) begin
            case (state)
                S_FETCH: imem_req_o = 1'b1;
                S_MEM: begin
                    dmem_req_o = 1'b1;
                    dmem_we_o  = (opcode == OP_ST);
                end
                S_IN:    in_ready_o  = 1'b1;
                S_OUT:   out_valid_o = 1'b1;
                S_HALT:  halted_o    = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc    <= '0;
            ir    <= '0;
            acc   <= '0;
            flags <= '0;
        end else begin
            case (state)
                S_FETCH: if (imem_valid_i) ir <= imem_rdata_i;
                S_EXEC: begin
                    case (opcode)
                        OP_ADDI: begin
                            acc           <= alu_result;
                            flags[FLAG_Z] <= alu_zero;
                            flags[FLAG_C] <= alu_carry;
                            pc            <= pc_next;
                        end
                        OP_LDI: begin
                            acc           <= imm;
                            flags[FLAG_Z] <= (imm == '0);
                            pc            <= pc_next;
                        end
                        OP_JMP:  pc <= target;
                        OP_JZ:   pc <= flags[FLAG_Z] ? target : pc_next;
                        OP_JC:   pc <= flags[FLAG_C] ? target : pc_next;
                        OP_NOP:  pc <= pc_next;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack_i) begin
                        pc <= pc_next;
                        if (opcode == OP_LD) begin
                            acc           <= dmem_rdata_i;
                            flags[FLAG_Z] <= (dmem_rdata_i == '0);
                        end else if (opcode != OP_ST) begin
                            acc           <= alu_result;
                            flags[FLAG_Z] <= alu_zero;
                            flags[FLAG_C] <= alu_carry;
                        end
                    end
                end
                S_IN: begin
                    if (in_valid_i) begin
                        acc           <= in_data_i;
                        flags[FLAG_Z] <= (in_data_i == '0);
                        pc            <= pc_next;
                    end
                end
                S_OUT:   if (out_ready_i) pc <= pc_next;
                default: ;
            endcase
        end
    end

    assign imem_addr_o  = pc;
    assign dmem_addr_o  = ir[AW-1:0];
    assign dmem_wdata_o = acc;
    assign out_data_o   = acc;
    assign pc_o         = pc;
    assign ins_o        = ir;
    assign acc_o        = acc;
    assign flags_o      = flags;

endmodule

// File: tb/tb_acc_core.sv
// Self-checking bench for acc_core: directed scenarios plus a randomized
// instruction stream checked against an instruction-level reference model.
module tb_acc_core;
    import acc_pkg::*;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic [IW-1:0] imem_rdata_i = '0;
    logic          imem_valid_i = 1'b0;
    logic          dmem_req_o;
    logic          dmem_we_o;
    logic [AW-1:0] dmem_addr_o;
    logic [DW-1:0] dmem_wdata_o;
    logic [DW-1:0] dmem_rdata_i = '0;
    logic          dmem_ack_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [AW-1:0] pc_o;
    logic [IW-1:0] ins_o;
    logic [DW-1:0] acc_o;
    logic [1:0]    flags_o;
    logic          halted_o;

    acc_core #(.DW(DW), .AW(AW), .IW(IW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata_i),
        .imem_valid_i (imem_valid_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_rdata_i (dmem_rdata_i),
        .dmem_ack_i   (dmem_ack_i),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .pc_o         (pc_o),
        .ins_o        (ins_o),
        .acc_o        (acc_o),
        .flags_o      (flags_o),
        .halted_o     (halted_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared data memory image and pending instruction stream
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [IW-1:0] iq [$];

    int ilat = 0, dlat = 0, inlat = 0, olat = 0;
    bit rand_mode = 0, rand_lat = 0;
    bit dir_in_valid = 0;
    logic [DW-1:0] dir_in_data = '0;

    // Reference model state: architectural view, advanced one instruction per fetch
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_acc;
    bit            m_c, m_z;
    logic [AW-1:0] cur_pc, exp_daddr;
    bit            exp_we;
    logic [DW-1:0] exp_wdata, exp_in, exp_out;

    int fetch_cnt = 0, last_fetch_cyc = 0, prev_fetch_cyc = 0;
    int dreq_len = 0, in_len = 0, out_len = 0, dack_cnt = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [AW-1:0] operand);
        iq.push_back({op, operand});
    endtask

    function automatic logic [IW-1:0] randIns();
        logic [3:0] op;
        op = 4'($urandom_range(0, 14));
        return {op, 12'($urandom)};
    endfunction

    task automatic modelExec(input logic [IW-1:0] ins);
        logic [3:0]    op;
        logic [AW-1:0] a;
        logic [DW-1:0] imm, opd;
        int            s;
        bit            taken;
        op  = ins[IW-1:IW-4];
        a   = ins[AW-1:0];
        imm = ins[DW-1:0];
        opd = mem[a];
        taken = 0;
        cur_pc = m_pc;
        exp_daddr = a;
        exp_we = 0;
        case (op)
            OP_ADD, OP_ADDI: begin
                s = int'(m_acc) + ((op == OP_ADD) ? int'(opd) : int'(imm));
                m_c = (s >= (1 << DW));
                m_acc = DW'(s);
                m_z = (m_acc == 0);
            end
            OP_SUB: begin
                m_c = (int'(m_acc) < int'(opd));
                m_acc = DW'(int'(m_acc) - int'(opd));
                m_z = (m_acc == 0);
            end
            OP_AND: begin m_acc = m_acc & opd; m_c = 0; m_z = (m_acc == 0); end
            OP_OR:  begin m_acc = m_acc | opd; m_c = 0; m_z = (m_acc == 0); end
            OP_XOR: begin m_acc = m_acc ^ opd; m_c = 0; m_z = (m_acc == 0); end
            OP_LDI: begin m_acc = imm; m_z = (m_acc == 0); end
            OP_LD:  begin m_acc = opd; m_z = (m_acc == 0); end
            OP_ST: begin
                exp_we = 1;
                exp_wdata = m_acc;
                mem[a] = m_acc;
            end
            OP_JMP: taken = 1;
            OP_JZ:  taken = m_z;
            OP_JC:  taken = m_c;
            OP_INP: begin
                exp_in = dir_in_valid ? dir_in_data : DW'($urandom);
                m_acc = exp_in;
                m_z = (m_acc == 0);
            end
            OP_OUT:  exp_out = m_acc;
            default: ;
        endcase
        if (taken) m_pc = a;
        else if (op != OP_HALT) m_pc = m_pc + AW'(1);
    endtask

    // Instruction memory responder; also owns the reference model
    int icnt = 0, icur = 0;
    always @(negedge clk) begin
        logic [IW-1:0] ins;
        if (!rst_n) begin
            m_pc = '0; m_acc = '0; m_c = 0; m_z = 0;
        end
        if (imem_req_o) begin
            if (icnt >= icur && (iq.size() > 0 || rand_mode)) begin
                if (iq.size() > 0) ins = iq.pop_front();
                else               ins = randIns();
                checkOutput("fetch_addr", 32'(imem_addr_o), 32'(m_pc));
                checkOutput("fetch_acc", 32'(acc_o), 32'(m_acc));
                checkOutput("fetch_flags", 32'(flags_o), 32'({m_c, m_z}));
                checkOutput("fetch_halted", 32'(halted_o), 32'(0));
                modelExec(ins);
                imem_rdata_i = ins;
                imem_valid_i = 1'b1;
                prev_fetch_cyc = last_fetch_cyc;
                last_fetch_cyc = cyc;
                fetch_cnt++;
            end else begin
                imem_valid_i = 1'b0;
                icnt++;
            end
        end else begin
            imem_valid_i = 1'b0;
            icnt = 0;
            icur = rand_lat ? int'($urandom_range(0, 2)) : ilat;
        end
    end

    int dcnt = 0, dcur = 0, dlen = 0;
    always @(negedge clk) begin
        if (dmem_req_o) begin
            dlen++;
            checkOutput("dmem_addr", 32'(dmem_addr_o), 32'(exp_daddr));
            checkOutput("dmem_we", 32'(dmem_we_o), 32'(exp_we));
            if (exp_we) checkOutput("dmem_wdata", 32'(dmem_wdata_o), 32'(exp_wdata));
            checkOutput("pc_hold_mem", 32'(pc_o), 32'(cur_pc));
            if (dcnt >= dcur) begin
                dmem_ack_i = 1'b1;
                dmem_rdata_i = mem[dmem_addr_o];
                dreq_len = dlen;
                dack_cnt++;
            end else begin
                dmem_ack_i = 1'b0;
                dmem_rdata_i = DW'($urandom);
                dcnt++;
            end
        end else begin
            dmem_ack_i = 1'b0;
            dcnt = 0;
            dlen = 0;
            dcur = rand_lat ? int'($urandom_range(0, 3)) : dlat;
        end
    end

    int incnt = 0, incur = 0, inl = 0;
    always @(negedge clk) begin
        if (in_ready_o) begin
            inl++;
            checkOutput("pc_hold_in", 32'(pc_o), 32'(cur_pc));
            if (incnt >= incur) begin
                in_valid_i = 1'b1;
                in_data_i = exp_in;
                in_len = inl;
            end else begin
                in_valid_i = 1'b0;
                in_data_i = DW'($urandom);
                incnt++;
            end
        end else begin
            in_valid_i = 1'b0;
            incnt = 0;
            inl = 0;
            incur = rand_lat ? int'($urandom_range(0, 3)) : inlat;
        end
    end

    int ocnt = 0, ocur = 0, ol = 0;
    always @(negedge clk) begin
        if (out_valid_o) begin
            ol++;
            checkOutput("out_data", 32'(out_data_o), 32'(exp_out));
            checkOutput("pc_hold_out", 32'(pc_o), 32'(cur_pc));
            if (ocnt >= ocur) begin
                out_ready_i = 1'b1;
                out_len = ol;
            end else begin
                out_ready_i = 1'b0;
                ocnt++;
            end
        end else begin
            out_ready_i = 1'b0;
            ocnt = 0;
            ol = 0;
            ocur = rand_lat ? int'($urandom_range(0, 3)) : olat;
        end
    end

    // Wait until every queued instruction has been fetched and the core is back in FETCH
    task automatic waitIdle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((iq.size() != 0 || !imem_req_o || imem_valid_i) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle_timeout"}, 32'(n < 300), 32'(1));
    endtask

    task automatic pulseReset(input string tag);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_rst_imem_req"}, 32'(imem_req_o), 32'(0));
        checkOutput({tag, "_rst_dmem_req"}, 32'(dmem_req_o), 32'(0));
        checkOutput({tag, "_rst_halted"}, 32'(halted_o), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_pc"}, 32'(pc_o), 32'(0));
        checkOutput({tag, "_acc"}, 32'(acc_o), 32'(0));
        checkOutput({tag, "_flags"}, 32'(flags_o), 32'(0));
        checkOutput({tag, "_fetch_req"}, 32'(imem_req_o), 32'(1));
    endtask

    initial begin
        int n, k, reqs, target;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);

        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_imem_req", 32'(imem_req_o), 32'(0));
        checkOutput("reset_in_ready", 32'(in_ready_o), 32'(0));
        checkOutput("reset_out_valid", 32'(out_valid_o), 32'(0));
        checkOutput("reset_pc", 32'(pc_o), 32'(0));
        checkOutput("reset_ir", 32'(ins_o), 32'(0));
        checkOutput("reset_acc", 32'(acc_o), 32'(0));
        checkOutput("reset_flags", 32'(flags_o), 32'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_fetch_req", 32'(imem_req_o), 32'(1));

        // LDI 5 ; ADDI FB -> 0 with carry and zero, two cycles each
        applyStimulus(OP_LDI, 12'h005);
        applyStimulus(OP_ADDI, 12'h0FB);
        waitIdle("addi");
        checkOutput("addi_acc", 32'(acc_o), 32'h00);
        checkOutput("addi_flags", 32'(flags_o), 32'b11);
        checkOutput("addi_pc", 32'(pc_o), 32'h002);
        checkOutput("cycles_per_insn", 32'(last_fetch_cyc - prev_fetch_cyc), 32'(2));

        // Store with three wait states
        dlat = 3;
        k = dack_cnt;
        applyStimulus(OP_LDI, 12'h05A);
        applyStimulus(OP_ST, 12'h010);
        waitIdle("st");
        checkOutput("st_req_cycles", 32'(dreq_len), 32'(4));
        checkOutput("st_ack_count", 32'(dack_cnt - k), 32'(1));
        checkOutput("st_pc", 32'(pc_o), 32'h004);
        dlat = 0;

        // Borrow from SUB, taken JC, untaken JZ
        applyStimulus(OP_LDI, 12'h004);
        applyStimulus(OP_ST, 12'h020);
        applyStimulus(OP_LDI, 12'h003);
        applyStimulus(OP_SUB, 12'h020);
        applyStimulus(OP_JC, 12'h100);
        applyStimulus(OP_JZ, 12'h200);
        waitIdle("sub_jump");
        checkOutput("sub_acc", 32'(acc_o), 32'hFF);
        checkOutput("sub_flags", 32'(flags_o), 32'b10);
        checkOutput("jump_pc", 32'(pc_o), 32'h101);

        // INP after five idle cycles, then OUT with a slow sink
        dir_in_valid = 1;
        dir_in_data = 8'hA5;
        inlat = 5;
        applyStimulus(OP_INP, 12'h000);
        waitIdle("inp");
        checkOutput("inp_ready_cycles", 32'(in_len), 32'(6));
        checkOutput("inp_acc", 32'(acc_o), 32'hA5);
        checkOutput("inp_flags", 32'(flags_o), 32'b10);
        olat = 4;
        applyStimulus(OP_OUT, 12'h000);
        waitIdle("out");
        checkOutput("out_valid_cycles", 32'(out_len), 32'(5));
        checkOutput("out_pc", 32'(pc_o), 32'h103);
        inlat = 0;
        olat = 0;
        dir_in_valid = 0;

        // PC wrap from the top of the address space
        applyStimulus(OP_JMP, 12'hFFF);
        applyStimulus(OP_NOP, 12'h000);
        waitIdle("wrap");
        checkOutput("wrap_fetch_addr", 32'(imem_addr_o), 32'h000);

        // Reset in the middle of a stalled store
        dlat = 50;
        applyStimulus(OP_LDI, 12'h077);
        applyStimulus(OP_ST, 12'h030);
        n = 0;
        while (!dmem_req_o && n < 100) begin @(negedge clk); n++; end
        checkOutput("midrst_mem_reached", 32'(n < 100), 32'(1));
        repeat (3) @(negedge clk);
        k = dack_cnt;
        pulseReset("midrst");
        checkOutput("midrst_dmem_req", 32'(dmem_req_o), 32'(0));
        reqs = 0;
        repeat (5) begin @(negedge clk); if (dmem_req_o) reqs++; end
        checkOutput("midrst_no_retry", 32'(reqs), 32'(0));
        checkOutput("midrst_no_ack", 32'(dack_cnt - k), 32'(0));
        dlat = 0;

        // HALT is absorbing until reset
        applyStimulus(OP_LDI, 12'h011);
        applyStimulus(OP_HALT, 12'h000);
        n = 0;
        while (iq.size() != 0 && n < 100) begin @(negedge clk); n++; end
        checkOutput("halt_fetched", 32'(n < 100), 32'(1));
        repeat (3) @(negedge clk);
        checkOutput("halt_flag", 32'(halted_o), 32'(1));
        checkOutput("halt_pc", 32'(pc_o), 32'h001);
        reqs = 0;
        repeat (10) begin @(negedge clk); if (imem_req_o || dmem_req_o) reqs++; end
        checkOutput("halt_no_requests", 32'(reqs), 32'(0));
        pulseReset("halt_exit");

        // Randomized instruction stream with random wait states
        rand_lat = 1;
        rand_mode = 1;
        target = fetch_cnt + 500;
        n = 0;
        while (fetch_cnt < target && n < 20000) begin @(negedge clk); n++; end
        checkOutput("random_progress", 32'(n < 20000), 32'(1));
        rand_mode = 0;
        waitIdle("random");
        rand_lat = 0;
        checkOutput("random_pc", 32'(pc_o), 32'(m_pc));
        checkOutput("random_acc", 32'(acc_o), 32'(m_acc));
        checkOutput("random_flags", 32'(flags_o), 32'({m_c, m_z}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
